mu_issue: RTL

Issue/writeback controller on the pipeline side of the multi-cycle multiply/divide unit (MU_EXU). It accepts one M-extension operation at a time from the execute stage, drives the unit's single-cycle start pulse, and waits for the one-cycle `dest_is_w` completion strobe. It then holds the result for writeback under a valid/ready handshake. It also absorbs pipeline flushes, because an operation already started in MU_EXU cannot be aborted.

---
 rtl/mu_issue_if.sv | 42 ++++
 rtl/mu_issue.sv | 119 +++++++++++
 2 files changed

// File: rtl/mu_issue_if.sv
// Handshake bundle for mu_issue: execute-stage offer, MU_EXU start/completion and writeback.
// master = the issue controller, slave = the surrounding pipeline and MU_EXU.
interface mu_issue_if #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned RD_W = 5
);
   localparam int unsigned TYPE_W = 7;

   logic              io_in_valid;
   logic              io_in_ready;
   logic [TYPE_W-1:0] io_in_exu_type;
   logic [XLEN-1:0]   io_in_rs1_data;
   logic [XLEN-1:0]   io_in_rs2_data;
   logic [RD_W-1:0]   io_in_rd;
   logic              io_flush;
   logic              io_mu_valid;
   logic [TYPE_W-1:0] io_mu_exu_type;
   logic [XLEN-1:0]   io_mu_rs1_data;
   logic [XLEN-1:0]   io_mu_rs2_data;
   logic [XLEN-1:0]   io_mu_dest_data;
   logic              io_mu_dest_is_w;
   logic              io_mu_ready;
   logic              io_wb_valid;
   logic              io_wb_ready;
   logic [RD_W-1:0]   io_wb_rd;
   logic [XLEN-1:0]   io_wb_data;
   logic              io_busy;

   modport master (
      input  io_in_valid, io_in_exu_type, io_in_rs1_data, io_in_rs2_data, io_in_rd, io_flush,
             io_mu_dest_data, io_mu_dest_is_w, io_mu_ready, io_wb_ready,
      output io_in_ready, io_mu_valid, io_mu_exu_type, io_mu_rs1_data, io_mu_rs2_data,
             io_wb_valid, io_wb_rd, io_wb_data, io_busy
   );

   modport slave (
      output io_in_valid, io_in_exu_type, io_in_rs1_data, io_in_rs2_data, io_in_rd, io_flush,
             io_mu_dest_data, io_mu_dest_is_w, io_mu_ready, io_wb_ready,
      input  io_in_ready, io_mu_valid, io_mu_exu_type, io_mu_rs1_data, io_mu_rs2_data,
             io_wb_valid, io_wb_rd, io_wb_data, io_busy
   );
endinterface

// File: rtl/mu_issue.sv
// Issue/writeback controller for the multi-cycle MU_EXU: one op in flight, flush-safe draining.
// Optional MU_ISSUE_REUSE_EN: one-entry result cache that bypasses MU_EXU on a repeated operation.
module mu_issue #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned RD_W = 5
) (
   input  logic        clock,
   input  logic        reset,
   mu_issue_if.master  bus
);
   localparam int unsigned TYPE_W = 7;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t            state, state_nx;
   logic              accept, capture, hit;
   logic [RD_W-1:0]   rd_q;
   logic [XLEN-1:0]   hit_data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // A started MU_EXU op cannot be aborted, so a flush in WAIT must drain its strobe.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.io_in_valid && !bus.io_flush) state_nx = hit ? S_DONE : S_ISSUE;
         S_ISSUE: if (bus.io_flush)                     state_nx = S_IDLE;
                  else if (bus.io_mu_ready)             state_nx = S_WAIT;
         S_WAIT:  if (bus.io_flush)                     state_nx = bus.io_mu_dest_is_w ? S_IDLE : S_DRAIN;
                  else if (bus.io_mu_dest_is_w)         state_nx = S_DONE;
         S_DRAIN: if (bus.io_mu_dest_is_w)              state_nx = S_IDLE;
         S_DONE:  if (bus.io_flush || bus.io_wb_ready)  state_nx = S_IDLE;
         default:                                       state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.io_in_ready = 1'b0;
      bus.io_busy     = 1'b1;
      bus.io_mu_valid = 1'b0;
      accept          = 1'b0;
      capture         = 1'b0;
      case (state)
         S_IDLE: begin
            bus.io_in_ready = 1'b1;
            bus.io_busy     = 1'b0;
            accept          = bus.io_in_valid && !bus.io_flush;
         end
         S_ISSUE: bus.io_mu_valid = bus.io_mu_ready && !bus.io_flush;
         S_WAIT:  capture         = bus.io_mu_dest_is_w && !bus.io_flush;
         default: ;
      endcase
   end

`ifdef MU_ISSUE_REUSE_EN
   logic              cache_vld;
   logic [TYPE_W-1:0] cache_type;
   logic [XLEN-1:0]   cache_rs1, cache_rs2, cache_res;

   assign hit      = cache_vld && (bus.io_in_exu_type == cache_type) &&
                     (bus.io_in_rs1_data == cache_rs1) && (bus.io_in_rs2_data == cache_rs2);
   assign hit_data = cache_res;

   // Only an op retired by a real writeback handshake is cached; flushed ones never are.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cache_vld  <= 1'b0;
         cache_type <= '0;
         cache_rs1  <= '0;
         cache_rs2  <= '0;
         cache_res  <= '0;
      end else if ((state == S_DONE) && bus.io_wb_ready && !bus.io_flush) begin
         cache_vld  <= 1'b1;
         cache_type <= bus.io_mu_exu_type;
         cache_rs1  <= bus.io_mu_rs1_data;
         cache_rs2  <= bus.io_mu_rs2_data;
         cache_res  <= bus.io_wb_data;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.io_mu_exu_type <= '0;
         bus.io_mu_rs1_data <= '0;
         bus.io_mu_rs2_data <= '0;
         rd_q               <= '0;
      end else if (accept) begin
         bus.io_mu_exu_type <= bus.io_in_exu_type;
         bus.io_mu_rs1_data <= bus.io_in_rs1_data;
         bus.io_mu_rs2_data <= bus.io_in_rs2_data;
         rd_q               <= bus.io_in_rd;
      end
   end

   // Writeback result is loaded once on entry to DONE and held until it leaves.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.io_wb_valid <= 1'b0;
         bus.io_wb_rd    <= '0;
         bus.io_wb_data  <= '0;
      end else begin
         bus.io_wb_valid <= (state_nx == S_DONE);
         if (capture) begin
            bus.io_wb_data <= bus.io_mu_dest_data;
            bus.io_wb_rd   <= rd_q;
         end else if (accept && hit) begin
            bus.io_wb_data <= hit_data;
            bus.io_wb_rd   <= bus.io_in_rd;
         end
      end
   end
endmodule
